// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, optional
// hardwired-zero r0, optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 wr_en,
  input  logic [2*ADDR_W-1:0]        wr_addr,
  input  logic [2*DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic [DEPTH-1:0]           busy_vec
);

  // Address maps to a real, writable register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic [ADDR_W-1:0] wa_a, wa_b;
  logic [DATA_W-1:0] wd_a, wd_b;
  logic              wok_a, wok_b, sb_ok;

  assign wa_a  = wr_addr[ADDR_W-1:0];
  assign wa_b  = wr_addr[2*ADDR_W-1:ADDR_W];
  assign wd_a  = wr_data[DATA_W-1:0];
  assign wd_b  = wr_data[2*DATA_W-1:DATA_W];
  assign wok_a = wr_en[0] && addr_ok(wa_a);
  assign wok_b = wr_en[1] && addr_ok(wa_b);
  assign sb_ok = sb_set && addr_ok(sb_addr);

  // Next state: port A then port B (B wins), write clears busy, set beats clear.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wok_a && (32'(wa_a) == i)) begin
        mem_d[i]  = wd_a;
        busy_d[i] = 1'b0;
      end
      if (wok_b && (32'(wa_b) == i)) begin
        mem_d[i]  = wd_b;
        busy_d[i] = 1'b0;
      end
      if (sb_ok && (32'(sb_addr) == i)) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // Storage and scoreboard registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdat;
  logic              rbsy;
  logic              hit;

  // Combinational read ports with optional bypass; forced quiet during reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbsy    = 1'b0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra   = rd_addr[k*ADDR_W +: ADDR_W];
      rdat = '0;
      rbsy = 1'b0;
      hit  = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (32'(ra) == i) begin
          rdat = mem_q[i];
          rbsy = busy_q[i];
        end
      end
      if (!addr_ok(ra)) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      if (BYPASS) begin
        if (wok_a && (wa_a == ra)) begin
          rdat = wd_a;
          hit  = 1'b1;
        end
        if (wok_b && (wa_b == ra)) begin
          rdat = wd_b;
          hit  = 1'b1;
        end
        // A retiring write makes the value available unless a new producer issues now.
        if (hit && !(sb_ok && (sb_addr == ra))) begin
          rbsy = 1'b0;
        end
      end
      if (!rst) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      rd_data[k*DATA_W +: DATA_W] = rdat;
      rd_busy[k]                  = rbsy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (default config, and a wide/shallow
// config without zero register or bypass) checked against an array model.
module tb_regfile_mp;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW0  = 32;
  localparam int unsigned DEP0 = 32;
  localparam int unsigned NR0  = 2;
  localparam bit          ZR0  = 1'b1;
  localparam bit          BY0  = 1'b1;
  localparam int unsigned DW1  = 64;
  localparam int unsigned DEP1 = 24;
  localparam int unsigned NR1  = 3;
  localparam bit          ZR1  = 1'b0;
  localparam bit          BY1  = 1'b0;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]          en0, en1;
  logic [2*AW-1:0]     wa0, wa1;
  logic [2*DW0-1:0]    wd0;
  logic [2*DW1-1:0]    wd1;
  logic [NR0*AW-1:0]   ra0;
  logic [NR1*AW-1:0]   ra1;
  logic [NR0*DW0-1:0]  rd0;
  logic [NR1*DW1-1:0]  rd1;
  logic [NR0-1:0]      rb0;
  logic [NR1-1:0]      rb1;
  logic                sbs0, sbs1;
  logic [AW-1:0]       sba0, sba1;
  logic [DEP0-1:0]     bv0;
  logic [DEP1-1:0]     bv1;

  int checks = 0;
  int errors = 0;

  // Reference state: m_mem[dut][reg], m_busy[dut][reg].
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];

  regfile_mp #(
    .DATA_W(DW0), .ADDR_W(AW), .DEPTH(DEP0), .NUM_RD(NR0), .ZERO_REG(ZR0), .BYPASS(BY0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(en0), .wr_addr(wa0), .wr_data(wd0), .rd_addr(ra0),
    .rd_data(rd0), .rd_busy(rb0), .sb_set(sbs0), .sb_addr(sba0), .busy_vec(bv0)
  );

  regfile_mp #(
    .DATA_W(DW1), .ADDR_W(AW), .DEPTH(DEP1), .NUM_RD(NR1), .ZERO_REG(ZR1), .BYPASS(BY1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(en1), .wr_addr(wa1), .wr_data(wd1), .rd_addr(ra1),
    .rd_data(rd1), .rd_busy(rb1), .sb_set(sbs1), .sb_addr(sba1), .busy_vec(bv1)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- configuration and stimulus accessors ----------------
  function automatic int dep(int d);  return (d == 0) ? DEP0 : DEP1; endfunction
  function automatic int nrd(int d);  return (d == 0) ? NR0 : NR1;   endfunction
  function automatic bit zr(int d);   return (d == 0) ? ZR0 : ZR1;   endfunction
  function automatic bit byp(int d);  return (d == 0) ? BY0 : BY1;   endfunction

  function automatic bit valid(int d, int a);
    return (a < dep(d)) && !(zr(d) && (a == 0));
  endfunction

  function automatic int f_wa(int d, int p);
    return (d == 0) ? int'(wa0[p*AW +: AW]) : int'(wa1[p*AW +: AW]);
  endfunction
  function automatic logic [63:0] f_wd(int d, int p);
    return (d == 0) ? 64'(wd0[p*DW0 +: DW0]) : wd1[p*DW1 +: DW1];
  endfunction
  function automatic bit f_en(int d, int p);
    return (d == 0) ? en0[p] : en1[p];
  endfunction
  function automatic int f_ra(int d, int k);
    return (d == 0) ? int'(ra0[k*AW +: AW]) : int'(ra1[k*AW +: AW]);
  endfunction
  function automatic int f_sba(int d);
    return (d == 0) ? int'(sba0) : int'(sba1);
  endfunction
  function automatic bit wr_ok(int d, int p);
    return f_en(d, p) && valid(d, f_wa(d, p));
  endfunction
  function automatic bit sb_ok(int d);
    return ((d == 0) ? sbs0 : sbs1) && valid(d, f_sba(d));
  endfunction

  function automatic logic [63:0] g_rd(int d, int k);
    return (d == 0) ? 64'(rd0[k*DW0 +: DW0]) : rd1[k*DW1 +: DW1];
  endfunction
  function automatic logic [63:0] g_busy(int d, int k);
    return (d == 0) ? 64'(rb0[k]) : 64'(rb1[k]);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] exp_data(int d, int k);
    int a;
    logic [63:0] r;
    a = f_ra(d, k);
    if (!rst || !valid(d, a)) return 64'd0;
    r = m_mem[d][a];
    if (byp(d)) begin
      if (wr_ok(d, 1) && f_wa(d, 1) == a)      r = f_wd(d, 1);
      else if (wr_ok(d, 0) && f_wa(d, 0) == a) r = f_wd(d, 0);
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_busy(int d, int k);
    int a;
    bit wr_hit;
    a = f_ra(d, k);
    if (!rst || !valid(d, a)) return 64'd0;
    wr_hit = (wr_ok(d, 0) && f_wa(d, 0) == a) || (wr_ok(d, 1) && f_wa(d, 1) == a);
    if (byp(d) && wr_hit && !(sb_ok(d) && f_sba(d) == a)) return 64'd0;
    return 64'(m_busy[d][a]);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[d][i]  = 64'd0;
        m_busy[d][i] = 1'b0;
      end
    end
  endtask

  // Clock-edge update: later port overrides, any write retires, new issue wins.
  task automatic model_step();
    bit ha, hb;
    if (!rst) return;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < dep(d); i++) begin
        ha = wr_ok(d, 0) && (f_wa(d, 0) == i);
        hb = wr_ok(d, 1) && (f_wa(d, 1) == i);
        if (hb)      m_mem[d][i] = f_wd(d, 1);
        else if (ha) m_mem[d][i] = f_wd(d, 0);
        if (sb_ok(d) && f_sba(d) == i) m_busy[d][i] = 1'b1;
        else if (ha || hb)             m_busy[d][i] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    logic [63:0] ev;
    logic [63:0] gv;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < nrd(d); k++) begin
        check_eq($sformatf("%s d%0d rd_data%0d", tag, d, k), g_rd(d, k), exp_data(d, k));
        check_eq($sformatf("%s d%0d rd_busy%0d", tag, d, k), g_busy(d, k), exp_busy(d, k));
      end
      ev = 64'd0;
      for (int i = 0; i < dep(d); i++) ev[i] = rst ? m_busy[d][i] : 1'b0;
      gv = (d == 0) ? 64'(bv0) : 64'(bv1);
      check_eq($sformatf("%s d%0d busy_vec", tag, d), gv, ev);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    en0 = '0; en1 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    sbs0 = 1'b0; sbs1 = 1'b0; sba0 = '0; sba1 = '0;
  endtask

  task automatic set_wr(int d, int p, int a, logic [63:0] data);
    logic [AW-1:0] aa;
    aa = a[AW-1:0];
    if (d == 0) begin
      en0[p] = 1'b1; wa0[p*AW +: AW] = aa; wd0[p*DW0 +: DW0] = data[DW0-1:0];
    end else begin
      en1[p] = 1'b1; wa1[p*AW +: AW] = aa; wd1[p*DW1 +: DW1] = data;
    end
  endtask

  task automatic set_sb(int d, int a);
    if (d == 0) begin sbs0 = 1'b1; sba0 = a[AW-1:0]; end
    else        begin sbs1 = 1'b1; sba1 = a[AW-1:0]; end
  endtask

  task automatic set_rd(int d, int k, int a);
    if (d == 0) ra0[k*AW +: AW] = a[AW-1:0];
    else        ra1[k*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_rd_all(int a);
    for (int d = 0; d < 2; d++) for (int k = 0; k < nrd(d); k++) set_rd(d, k, a);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    check_outputs(tag);
    advance();
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(6, 9)) : int'($urandom_range(0, 31));
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    idle();
    ra0 = '0;
    ra1 = '0;
    model_clear();
    #2;
    check_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    advance();

    // Fill every register and mark it busy.
    for (int i = 0; i < 32; i++) begin
      idle();
      set_rd_all(i);
      for (int d = 0; d < 2; d++) begin
        set_wr(d, 0, i, {2{32'hA5A5A5A5}});
        set_sb(d, i);
      end
      cycle("fill");
    end
    idle();
    set_rd_all(3);
    @(negedge clk);
    check_outputs("filled");
    check_eq("filled r3", g_rd(0, 0), 64'hA5A5A5A5);
    check_eq("filled busy_vec0", 64'(bv0), 64'hFFFFFFFE);
    check_eq("filled busy_vec1", 64'(bv1), 64'hFFFFFF);

    // Asynchronous reset between edges with a write in flight.
    #1;
    set_wr(0, 0, 3, 64'h0BAD);
    set_wr(1, 0, 3, 64'h0BAD);
    set_sb(0, 4);
    rst = 1'b0;
    model_clear();
    #1;
    check_outputs("async_rst");
    check_eq("async_rst rd0", g_rd(0, 0), 64'd0);
    check_eq("async_rst bv0", 64'(bv0), 64'd0);
    check_eq("async_rst bv1", 64'(bv1), 64'd0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check_outputs("rst_hold");
    rst = 1'b1;
    advance();

    // Basic write/read; r0 write ignored on dut0; seed dut1 r7.
    idle();
    set_rd_all(5);
    set_wr(0, 0, 5, 64'h12345678);
    set_wr(0, 1, 0, 64'hFFFFFFFF);
    set_wr(1, 0, 5, 64'h12345678);
    set_wr(1, 1, 7, 64'h77);
    cycle("basic_wr");
    idle();
    set_rd(0, 0, 5);
    set_rd(0, 1, 0);
    @(negedge clk);
    check_outputs("basic_rd");
    check_eq("basic r5 port0", g_rd(0, 0), 64'h12345678);
    check_eq("basic r0 zero", g_rd(0, 1), 64'd0);
    for (int k = 0; k < 3; k++) check_eq($sformatf("basic d1 r5 port%0d", k), g_rd(1, k),
                                        64'h12345678);
    advance();
    set_rd(0, 1, 5);
    @(negedge clk);
    check_eq("basic r5 port1", g_rd(0, 1), 64'h12345678);
    advance();

    // Collision: port B wins; bypass shows it same cycle, no-bypass shows old.
    idle();
    set_rd_all(7);
    for (int d = 0; d < 2; d++) begin
      set_wr(d, 0, 7, 64'h11);
      set_wr(d, 1, 7, 64'h22);
    end
    @(negedge clk);
    check_outputs("coll");
    check_eq("coll bypass", g_rd(0, 0), 64'h22);
    check_eq("coll no_bypass", g_rd(1, 0), 64'h77);
    advance();
    idle();
    @(negedge clk);
    check_outputs("coll_after");
    check_eq("coll after d0", g_rd(0, 1), 64'h22);
    check_eq("coll after d1", g_rd(1, 2), 64'h22);
    advance();

    // Scoreboard on r9.
    idle();
    set_rd_all(9);
    set_sb(0, 9);
    set_sb(1, 9);
    @(negedge clk);
    check_outputs("sb_set");
    check_eq("sb_set not yet", g_busy(0, 0), 64'd0);
    advance();
    idle();
    @(negedge clk);
    check_outputs("sb_vis");
    check_eq("sb visible d0", g_busy(0, 0), 64'd1);
    check_eq("sb visible d1", g_busy(1, 1), 64'd1);
    advance();
    idle();
    set_wr(0, 0, 9, 64'h99);
    set_wr(1, 0, 9, 64'h99);
    @(negedge clk);
    check_outputs("sb_wr");
    check_eq("sb_wr bypass clears", g_busy(0, 0), 64'd0);
    check_eq("sb_wr no_bypass busy", g_busy(1, 0), 64'd1);
    advance();
    idle();
    @(negedge clk);
    check_outputs("sb_clr");
    check_eq("sb cleared d0", 64'(bv0[9]), 64'd0);
    check_eq("sb cleared d1", 64'(bv1[9]), 64'd0);
    advance();
    idle();
    set_sb(0, 9);
    set_sb(1, 9);
    set_wr(0, 1, 9, 64'h9A);
    set_wr(1, 1, 9, 64'h9A);
    cycle("sb_both");
    idle();
    @(negedge clk);
    check_outputs("sb_both_after");
    check_eq("set beats clear d0", g_busy(0, 0), 64'd1);
    check_eq("set beats clear d1", g_busy(1, 0), 64'd1);
    advance();

    // Range and zero guards.
    idle();
    set_rd_all(30);
    set_wr(1, 0, 30, 64'hF00D);
    set_sb(1, 30);
    set_sb(0, 0);
    cycle("guard");
    idle();
    @(negedge clk);
    check_outputs("guard_after");
    check_eq("range rd_data", g_rd(1, 0), 64'd0);
    check_eq("range rd_busy", g_busy(1, 0), 64'd0);
    check_eq("zero busy_vec0", 64'(bv0[0]), 64'd0);
    advance();

    // No zero register on dut1: r0 is ordinary storage.
    idle();
    set_rd_all(0);
    set_wr(1, 0, 0, 64'hDEADBEEFCAFEF00D);
    cycle("r0_wr");
    idle();
    @(negedge clk);
    check_outputs("r0_rd");
    for (int k = 0; k < 3; k++) check_eq($sformatf("r0 d1 port%0d", k), g_rd(1, k),
                                        64'hDEADBEEFCAFEF00D);
    advance();

    // Randomised traffic, biased toward a few hot registers.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if ($urandom_range(0, 2) != 0) set_wr(d, p, rnd_addr(), {$urandom, $urandom});
        end
        if ($urandom_range(0, 2) == 0) set_sb(d, rnd_addr());
        for (int k = 0; k < nrd(d); k++) begin
          if ($urandom_range(0, 2) == 0) set_rd(d, k, f_wa(d, $urandom_range(0, 1)));
          else                           set_rd(d, k, rnd_addr());
        end
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
